// File: rtl/ram_march_bist_if.sv
// RAM-side bus of the March C- BIST initiator: the word-addressed DFFRAM
// macro port (EN, byte WE, A, Di, Do).
//   master : BIST side, drives EN/WE/A/Di and samples Do
//   slave  : RAM side, samples EN/WE/A/Di and drives Do
// Do returns the word addressed by a read cycle (EN=1, WE=0) one clock later.
interface ram_march_bist_if #(
  parameter int AW = 13
);
  logic          EN;
  logic [3:0]    WE;
  logic [AW-1:0] A;
  logic [31:0]   Di;
  logic [31:0]   Do;

  modport master (output EN, output WE, output A, output Di, input Do);
  modport slave  (input EN, input WE, input A, input Di, output Do);
endinterface

// File: rtl/ram_march_bist.sv
// March C- built-in self-test initiator for a DFFRAM macro.
// On an accepted start the RAM is walked through
//   M0 up   w(BG)
//   M1 up   r(BG)  w(~BG)
//   M2 up   r(~BG) w(BG)
//   M3 down r(BG)  w(~BG)
//   M4 down r(~BG) w(BG)
//   M5 down r(BG)
// and every read is compared against the expected background. The first
// mismatch ends the run and is captured in fail_addr/fail_exp/fail_got.
// Ports:
//   CLK, RST      clock and asynchronous active-high reset
//   start         level request, accepted only in IDLE or DONE
//   busy          high while a march element is running
//   done          high from completion until the next accepted start
//   pass          valid with done; 1 means every read matched
//   fail_addr/exp/got  first mismatch address, expected word, read word
//   ram           RAM bus (master modport), decoded combinationally from
//                 the state register so an asynchronous reset drops EN/WE
//                 at once
module ram_march_bist #(
  parameter int          AW    = 13,
  parameter int          DEPTH = 6144,
  parameter logic [31:0] BG    = 32'h0000_0000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [AW-1:0]       fail_addr,
  output logic [31:0]         fail_exp,
  output logic [31:0]         fail_got,
  ram_march_bist_if.master    ram
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ZERO = '0;
  localparam logic [AW-1:0] ONE  = AW'(1);

  typedef enum logic [3:0] {
    IDLE,
    M0,
    M1,
    M2,
    M3,
    M4,
    M5,
    DONE
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic          ph_c, ph_c_n;     // 0: read cycle R, 1: compare/write cycle C
  logic          pass_n;
  logic [AW-1:0] fail_addr_n;
  logic [31:0]   fail_exp_n;
  logic [31:0]   fail_got_n;

  logic          en_c;
  logic [3:0]    we_c;
  logic [AW-1:0] a_c;
  logic [31:0]   di_c;

  // Background each read element expects to find.
  function automatic logic [31:0] read_exp(input state_t s);
    case (s)
      M2, M4:  read_exp = ~BG;
      default: read_exp = BG;
    endcase
  endfunction

  // Value written in the C cycle of M1..M4 (M0 writes BG in its only cycle).
  function automatic logic [31:0] write_val(input state_t s);
    case (s)
      M1, M3:  write_val = ~BG;
      default: write_val = BG;
    endcase
  endfunction

  function automatic logic is_down(input state_t s);
    is_down = (s == M3) || (s == M4) || (s == M5);
  endfunction

  // Element that follows s once its last address completes.
  function automatic state_t next_elem(input state_t s);
    case (s)
      M0:      next_elem = M1;
      M1:      next_elem = M2;
      M2:      next_elem = M3;
      M3:      next_elem = M4;
      M4:      next_elem = M5;
      default: next_elem = DONE;
    endcase
  endfunction

  function automatic logic words_differ(input logic [31:0] got,
                                        input logic [31:0] exp);
    words_differ = (got != exp);
  endfunction

  // Registered state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      addr      <= '0;
      ph_c      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_got  <= '0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      ph_c      <= ph_c_n;
      pass      <= pass_n;
      fail_addr <= fail_addr_n;
      fail_exp  <= fail_exp_n;
      fail_got  <= fail_got_n;
    end
  end

  // Next-state, address walk and comparison
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    ph_c_n      = ph_c;
    pass_n      = pass;
    fail_addr_n = fail_addr;
    fail_exp_n  = fail_exp;
    fail_got_n  = fail_got;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = M0;
          addr_n      = '0;
          ph_c_n      = 1'b0;
          pass_n      = 1'b0;
          fail_addr_n = '0;
          fail_exp_n  = '0;
          fail_got_n  = '0;
        end
      end

      M0: begin
        if (addr == LAST) begin
          state_n = M1;
          addr_n  = '0;
        end else begin
          addr_n = addr + ONE;
        end
      end

      M1, M2, M3, M4, M5: begin
        if (!ph_c) begin
          ph_c_n = 1'b1;
        end else if (words_differ(ram.Do, read_exp(state))) begin
          // First failure ends the run; the write already on the bus
          // in this cycle still lands in the RAM.
          state_n     = DONE;
          ph_c_n      = 1'b0;
          pass_n      = 1'b0;
          fail_addr_n = addr;
          fail_exp_n  = read_exp(state);
          fail_got_n  = ram.Do;
        end else begin
          ph_c_n = 1'b0;
          if (is_down(state) ? (addr == ZERO) : (addr == LAST)) begin
            state_n = next_elem(state);
            // M3..M5 all start from the top address; M1/M2 from zero.
            addr_n  = (next_elem(state) == M2) ? ZERO : LAST;
            if (state == M5) begin
              addr_n = '0;
              pass_n = 1'b1;
            end
          end else begin
            addr_n = is_down(state) ? (addr - ONE) : (addr + ONE);
          end
        end
      end

      default: begin
        state_n = IDLE;
        addr_n  = '0;
        ph_c_n  = 1'b0;
      end
    endcase
  end

  // RAM bus decode; every field is zero outside the march elements.
  always_comb begin
    en_c = 1'b0;
    we_c = 4'h0;
    a_c  = '0;
    di_c = '0;

    case (state)
      M0: begin
        en_c = 1'b1;
        we_c = 4'hF;
        a_c  = addr;
        di_c = BG;
      end
      M1, M2, M3, M4: begin
        en_c = 1'b1;
        a_c  = addr;
        if (ph_c) begin
          we_c = 4'hF;
          di_c = write_val(state);
        end
      end
      M5: begin
        en_c = !ph_c;
        a_c  = addr;
      end
      default: ;
    endcase
  end

  assign ram.EN = en_c;
  assign ram.WE = we_c;
  assign ram.A  = a_c;
  assign ram.Di = di_c;

  assign busy = (state == M0) || (state == M1) || (state == M2) ||
                (state == M3) || (state == M4) || (state == M5);
  assign done = (state == DONE);

endmodule

// File: tb/tb_ram_march_bist.sv
// Directed bench for ram_march_bist with DEPTH=16 against a behavioural
// RAM that can model a stuck-at-0 bit and a stuck-at-1 byte.
module tb_ram_march_bist;
  localparam int AW    = 6;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW-1:0] fail_addr;
  logic [31:0]   fail_exp;
  logic [31:0]   fail_got;

  int n_cmp = 0;
  int n_err = 0;

  ram_march_bist_if #(.AW(AW)) ram ();

  ram_march_bist #(.AW(AW), .DEPTH(DEPTH), .BG(32'h0000_0000)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_exp  (fail_exp),
    .fail_got  (fail_got),
    .ram       (ram)
  );

  always #5 CLK = ~CLK;

  // Behavioural RAM; faults are applied on the read path.
  logic [31:0] mem [0:15];
  int          fmode = 0;   // 0 none, 1 addr7 bit5 stuck-at-0, 2 addr0 byte0 stuck-at-1

  function automatic logic [31:0] faulted(input logic [3:0] idx, input logic [31:0] w);
    logic [31:0] r;
    r = w;
    if (fmode == 1 && idx == 4'd7) r = w & ~32'h0000_0020;
    if (fmode == 2 && idx == 4'd0) r = w | 32'h0000_00FF;
    return r;
  endfunction

  always @(posedge CLK) begin
    if (ram.EN) begin
      if (ram.WE != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (ram.WE[b]) mem[ram.A[3:0]][8*b +: 8] <= ram.Di[8*b +: 8];
      end else begin
        ram.Do <= faulted(ram.A[3:0], mem[ram.A[3:0]]);
      end
    end
  end

  // Bus monitor: write-address log, C-repeats-R and range checks.
  bit            mon_en = 1'b0;
  int            wr_a[$];
  int            c_err = 0;
  int            oob = 0;
  logic          prev_r = 1'b0;
  logic [AW-1:0] prev_a = '0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (ram.EN && ram.WE == 4'hF) wr_a.push_back(int'(ram.A));
      if (prev_r && ram.A != prev_a) c_err <= c_err + 1;
      if (ram.EN && int'(ram.A) >= DEPTH) oob <= oob + 1;
      prev_r <= ram.EN && (ram.WE == 4'h0);
      prev_a <= ram.A;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse (or hold) start from a negedge, then count busy cycles at negedges.
  task automatic run(input bit hold, output int cyc);
    @(negedge CLK) start = 1'b1;
    @(negedge CLK);
    if (!hold) start = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int          cyc;
    int          en_seen;
    int          exp_a[$];
    logic [31:0] acc;

    RST   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_busy",      busy,      0);
    chk("rst_done",      done,      0);
    chk("rst_pass",      pass,      0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_exp",  fail_exp,  0);
    chk("rst_fail_got",  fail_got,  0);
    chk("rst_en",        ram.EN,    0);
    chk("rst_we",        ram.WE,    0);
    chk("rst_a",         ram.A,     0);
    chk("rst_di",        ram.Di,    0);
    RST = 1'b0;
    @(negedge CLK);

    // Clean run with bus monitoring
    mon_en = 1'b1;
    run(1'b0, cyc);
    mon_en = 1'b0;
    chk("clean_busy_cycles", cyc, 176);
    chk("clean_done",      done,      1);
    chk("clean_pass",      pass,      1);
    chk("clean_fail_addr", fail_addr, 0);
    chk("clean_fail_exp",  fail_exp,  0);
    chk("clean_fail_got",  fail_got,  0);
    chk("clean_en_idle",   ram.EN,    0);
    acc = '0;
    for (int i = 0; i < 16; i++) acc = acc | mem[i];
    chk("clean_ram_zero", acc, 0);

    for (int i = 0; i < 16; i++)  exp_a.push_back(i);   // M0
    for (int i = 0; i < 16; i++)  exp_a.push_back(i);   // M1
    for (int i = 0; i < 16; i++)  exp_a.push_back(i);   // M2
    for (int i = 15; i >= 0; i--) exp_a.push_back(i);   // M3
    for (int i = 15; i >= 0; i--) exp_a.push_back(i);   // M4
    chk("wr_count", wr_a.size(), 80);
    for (int i = 0; i < 80 && i < wr_a.size(); i++)
      chk($sformatf("wr_addr[%0d]", i), wr_a[i], exp_a[i]);
    chk("c_repeats_r", c_err, 0);
    chk("a_in_range",  oob,   0);

    repeat (3) @(negedge CLK);
    chk("done_holds", done, 1);
    chk("pass_holds", pass, 1);

    // Stuck-at-0: bit 5 of address 7, caught by the M2 read
    fmode = 1;
    run(1'b0, cyc);
    chk("sa0_busy_cycles", cyc, 64);
    chk("sa0_done",      done,      1);
    chk("sa0_pass",      pass,      0);
    chk("sa0_fail_addr", fail_addr, 7);
    chk("sa0_fail_exp",  fail_exp,  32'hFFFF_FFFF);
    chk("sa0_fail_got",  fail_got,  32'hFFFF_FFDF);
    en_seen = 0;
    repeat (5) begin
      if (ram.EN) en_seen++;
      @(negedge CLK);
    end
    chk("sa0_no_en_after", en_seen, 0);

    // Stuck-at-1: byte 0 of address 0, caught by the first M1 read
    fmode = 2;
    run(1'b0, cyc);
    chk("sa1_busy_cycles", cyc, 18);
    chk("sa1_pass",      pass,      0);
    chk("sa1_fail_addr", fail_addr, 0);
    chk("sa1_fail_exp",  fail_exp,  32'h0000_0000);
    chk("sa1_fail_got",  fail_got,  32'h0000_00FF);

    // Asynchronous reset in the middle of M3 (busy cycle 90)
    fmode = 0;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    repeat (89) @(negedge CLK);
    chk("mid_busy_before", busy,   1);
    chk("mid_en_before",   ram.EN, 1);
    RST = 1'b1;
    #1;
    chk("mid_rst_en",   ram.EN, 0);
    chk("mid_rst_we",   ram.WE, 0);
    chk("mid_rst_busy", busy,   0);
    chk("mid_rst_done", done,   0);
    #1 RST = 1'b0;
    run(1'b0, cyc);
    chk("after_rst_cycles", cyc,  176);
    chk("after_rst_pass",   pass, 1);

    // start held high: ignored while busy, re-accepted from DONE
    run(1'b1, cyc);
    chk("hold_busy_cycles", cyc,  176);
    chk("hold_done",        done, 1);
    chk("hold_pass",        pass, 1);
    @(negedge CLK);
    chk("hold_restart_busy", busy, 1);
    chk("hold_restart_done", done, 0);
    start = 1'b0;
    cyc = 1;
    while (busy && cyc < 2000) begin
      @(negedge CLK);
      if (busy) cyc++;
    end
    chk("hold_second_cycles", cyc,  176);
    chk("hold_second_pass",   pass, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
